instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface: owns the program counter, drives word addresses into the instruction memory and captures the returned 32-bit instruction words.
- Instruction memory has registered read: address sampled at posedge N, data valid throughout cycle N+1.
- Fetch unit tracks in-flight requests, buffers up to 2 returned words and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush) and PC wrap-around.

---
 rtl/instr_fetch_unit.sv | 73 +++++++
 tb/tb_instr_fetch_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch engine for a registered-read instruction memory, 2-deep decode buffer.
//   clk, reset (sync, active-low)
//   imem_addr -> / imem_data <- : word address out, registered read data back one cycle later
//   redirect_valid, redirect_pc : taken branch/jump, flushes buffered and in-flight words
//   instr_valid, instr, instr_pc, instr_ready : valid/ready handshake towards decode
module instr_fetch_unit #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);
  logic [ADDR_W-1:0] fetch_pc, inflight_pc, head_pc, tail_pc;
  logic [DATA_W-1:0] head_instr, tail_instr;
  logic              inflight, pop, push, issue;
  logic [1:0]        count;
  logic [2:0]        occ;
  assign imem_addr   = redirect_valid ? redirect_pc : fetch_pc;
  assign instr_valid = count != 2'd0;
  assign instr       = head_instr;
  assign instr_pc    = head_pc;
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight & ~redirect_valid;
  // buffered plus in-flight words never exceed the two buffer slots
  assign occ         = {1'b0, count} + {2'b0, inflight};
  assign issue       = redirect_valid | (occ < 3'd2) | ((occ == 3'd2) & pop);
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      head_pc     <= '0;
      head_instr  <= '0;
      tail_pc     <= '0;
      tail_instr  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_addr;
        fetch_pc    <= imem_addr + ADDR_W'(1);
      end
      if (redirect_valid)
        count <= 2'd0;
      else begin
        count <= count + 2'(push) - 2'(pop);
        // head is a shift register: it keeps its last word when the buffer drains
        if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
          head_pc    <= inflight_pc;
          head_instr <= imem_data;
        end else if (pop && count == 2'd2) begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
        end
        if (push && ((count == 2'd1 && !pop) || count == 2'd2)) begin
          tail_pc    <= inflight_pc;
          tail_instr <= imem_data;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) assert (!(push && count == 2'd2 && !pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a registered-read instruction memory model.
module tb_instr_fetch_unit;
  typedef struct packed {
    int         cyc;
    logic [5:0] pc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_ready;
  logic [31:0] mem [64];
  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = -1;
  instr_fetch_unit #(.ADDR_W(6), .DATA_W(32), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic expect_pc(input int c, input int pc);
    q.push_back('{cyc: c, pc: 6'(pc)});
  endtask
  // monitor: every accepted transfer must match the oldest expected entry, including its cycle
  always @(negedge clk) begin
    if (cyc >= 0 && reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      exp_t e;
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pop: cycle %0d pc %0d instr %h, expected no transfer", cyc, instr_pc, instr);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || instr_pc !== e.pc || instr !== 32'hA000_0000 + 32'(e.pc)) begin
          mismatched++;
          $display("FAIL pop: cycle %0d pc %0d instr %h, expected cycle %0d pc %0d instr %h",
                   cyc, instr_pc, instr, e.cyc, e.pc, 32'hA000_0000 + 32'(e.pc));
        end
      end
    end
  end
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + 32'(k);
    reset = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_pc", 32'(instr_pc), 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i <= 37; i++) begin
      cyc = i;
      reset = (i != 31);
      instr_ready = !((i >= 6 && i <= 10) || i == 12 || (i >= 22 && i <= 24) || (i >= 29 && i <= 31) || i >= 37);
      redirect_valid = (i == 12 || i == 16 || i == 24);
      redirect_pc = (i == 12) ? 6'd40 : (i == 16) ? 6'd62 : (i == 24) ? 6'd10 : 6'd0;
      case (i)
        0: for (int k = 0; k < 4; k++) expect_pc(k + 2, k);
        1: expect_pc(11, 4);
        12: for (int k = 0; k < 3; k++) expect_pc(k + 14, 40 + k);
        16: begin expect_pc(18, 62); expect_pc(19, 63); expect_pc(20, 0); expect_pc(21, 1); end
        24: for (int k = 0; k < 3; k++) expect_pc(k + 26, 10 + k);
        32: for (int k = 0; k < 3; k++) expect_pc(k + 34, k);
        default: ;
      endcase
      @(negedge clk);
      if (i == 0 || i == 1) chk("startup_valid", 32'(instr_valid), 32'd0);
      if (i == 2) chk("first_valid", 32'(instr_valid), 32'd1);
      if (i >= 7 && i <= 10) begin
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_pc", 32'(instr_pc), 32'd4);
        chk("stall_instr", instr, 32'hA000_0004);
        chk("stall_addr", 32'(imem_addr), 32'd6);
      end
      if (i == 13 || i == 17 || i == 25) chk("flush_valid", 32'(instr_valid), 32'd0);
      if (i == 23 || i == 24) chk("full_head_pc", 32'(instr_pc), 32'd2);
      if (i == 32) begin
        chk("midreset_valid", 32'(instr_valid), 32'd0);
        chk("midreset_instr", instr, 32'd0);
        chk("midreset_pc", 32'(instr_pc), 32'd0);
        chk("midreset_addr", 32'(imem_addr), 32'd0);
      end
      if (i == 33) chk("restart_valid", 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("leftover_expected", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
